add12_operand_stage: RTL and testbench

Pipelined front-end/back-end stage that wraps the 12-bit Brent-Kung adder. It accepts operand pairs over a valid/ready handshake and registers them onto the adder's interleaved 24-bit input bus. It captures the adder's 13-bit result into an output register with its own valid/ready handshake. It also keeps a 12-bit running accumulator, so a stream of operands can be summed without an external feedback path.

---
 rtl/add12_operand_stage.sv | 64 ++++++
 tb/tb_add12_operand_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/add12_operand_stage.sv
// add12_operand_stage: handshaked operand/result register stages around a 12-bit adder with running accumulator
module add12_operand_stage #(
    parameter int W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_acc,
    output logic [2*W-1:0]   adder_in,
    input  logic [W:0]       adder_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W:0]       res_sum,
    output logic             ovf,
    input  logic             ovf_clr
);
    logic           op_v;
    logic           op_adv;
    logic           accept;
    logic [W-1:0]   acc;
    logic [W-1:0]   bsel;
    logic [2*W-1:0] inter;

    assign op_adv   = op_v & (!res_valid | res_ready);
    assign in_ready = !op_v | op_adv;
    assign accept   = in_valid & in_ready;
    // forward the in-flight sum so back-to-back accumulate ops need no bubble
    assign bsel     = in_acc ? (op_adv ? adder_out[W-1:0] : acc) : in_b;

    for (genvar i = 0; i < W; i++) begin : g_ilv
        assign inter[2*i]   = in_a[i];
        assign inter[2*i+1] = bsel[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_v      <= 1'b0;
            adder_in  <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                op_v     <= 1'b1;
                adder_in <= inter;
            end else if (op_adv) begin
                op_v <= 1'b0;
            end
            if (op_adv) begin
                res_sum   <= adder_out;
                res_valid <= 1'b1;
                acc       <= adder_out[W-1:0];
            end else if (res_valid & res_ready) begin
                res_valid <= 1'b0;
            end
            if (op_adv & adder_out[W]) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add12_operand_stage.sv
// tb_add12_operand_stage: directed and random checks against an in-order scoreboard model
module tb_add12_operand_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic        in_acc = 1'b0;
    logic [23:0] adder_in;
    logic [12:0] adder_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [12:0] res_sum;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] q[$];
    bit          head_cap = 0;
    logic [11:0] accm = '0;
    bit          ovf_m = 0;

    add12_operand_stage #(.W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .adder_in(adder_in),
        .adder_out(adder_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // behavioural adder on the far side of the interleaved bus
    always_comb begin
        logic [11:0] x, y;
        x = '0;
        y = '0;
        for (int i = 0; i < 12; i++) begin
            x[i] = adder_in[2*i];
            y[i] = adder_in[2*i+1];
        end
        adder_out = {1'b0, x} + {1'b0, y};
    end

    function automatic logic [23:0] ilv(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        head_cap = 0;
        accm = '0;
        ovf_m = 0;
        chk("rst_adder_in", adder_in, 24'h0);
        chk("rst_res_sum", res_sum, 24'h0);
        chk("rst_res_valid", res_valid, 24'h0);
        chk("rst_in_ready", in_ready, 24'h1);
        chk("rst_ovf", ovf, 24'h0);
    endtask

    // one clock: check registered outputs, drive inputs, check in_ready, advance and update the model
    task automatic step(input bit v, input logic [11:0] a, input logic [11:0] b,
                        input bit ac, input bit rr, input bit clr);
        bit ire, hsi, hso, set;
        logic [11:0] bs;
        logic [12:0] s;
        chk("res_valid", res_valid, head_cap);
        if (head_cap) chk("res_sum", res_sum, q[0]);
        chk("ovf", ovf, ovf_m);
        in_valid = v; in_a = a; in_b = b; in_acc = ac; res_ready = rr; ovf_clr = clr;
        #1;
        ire = (q.size() < 2) || rr;
        chk("in_ready", in_ready, ire);
        hsi = v && ire;
        hso = head_cap && rr;
        bs = ac ? accm : b;
        s = {1'b0, a} + {1'b0, bs};
        @(posedge clk);
        #1;
        if (hso) begin
            void'(q.pop_front());
            head_cap = 0;
        end
        set = 0;
        if (q.size() > 0 && !head_cap) begin
            head_cap = 1;
            set = q[0][12];
        end
        ovf_m = set ? 1'b1 : (clr ? 1'b0 : ovf_m);
        if (hsi) begin
            q.push_back(s);
            accm = s[11:0];
            chk("adder_in", adder_in, ilv(a, bs));
        end
        in_valid = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        do_reset();
        // single op and latency
        step(1, 12'h123, 12'h456, 0, 1, 0);
        chk("ilv_const", adder_in, ilv(12'h123, 12'h456));
        chk("lat_valid_early", res_valid, 24'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("lat_valid", res_valid, 24'h1);
        chk("sum_579", res_sum, 24'h0579);
        chk("ovf_none", ovf, 24'h0);
        step(0, 0, 0, 0, 1, 0);
        // carry, clear, clear colliding with set
        step(1, 12'hFFF, 12'h001, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("sum_1000", res_sum, 24'h1000);
        chk("ovf_set", ovf, 24'h1);
        step(0, 0, 0, 0, 1, 1);
        chk("ovf_clr", ovf, 24'h0);
        step(1, 12'hFFF, 12'h001, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("ovf_set_wins", ovf, 24'h1);
        step(0, 0, 0, 0, 1, 0);
        // back-to-back accumulate with forwarding
        do_reset();
        step(1, 12'h800, 12'hABC, 1, 1, 0);
        step(1, 12'h800, 12'h123, 1, 1, 0);
        chk("acc_r0", res_sum, 24'h0800);
        step(1, 12'h001, 12'h777, 1, 1, 0);
        chk("acc_r1", res_sum, 24'h1000);
        step(0, 0, 0, 0, 1, 0);
        chk("acc_r2", res_sum, 24'h0001);
        step(0, 0, 0, 0, 1, 0);
        // backpressure
        step(1, 12'h010, 12'h001, 0, 0, 0);
        step(1, 12'h020, 12'h002, 0, 0, 0);
        chk("bp_full", in_ready, 24'h0);
        step(1, 12'h030, 12'h003, 0, 0, 0);
        chk("bp_hold", res_sum, 24'h0011);
        step(1, 12'h030, 12'h003, 0, 1, 0);
        chk("bp_order", res_sum, 24'h0022);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        // reset with both stages full
        step(1, 12'h111, 12'h111, 0, 0, 0);
        step(1, 12'h222, 12'h222, 0, 0, 0);
        do_reset();
        step(1, 12'h005, 12'h0F0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("post_rst_acc", res_sum, 24'h0005);
        step(0, 0, 0, 0, 1, 0);
        // random mix
        for (int n = 0; n < 400; n++)
            step(bit'($urandom_range(0, 1)), 12'($urandom), 12'($urandom),
                 bit'($urandom_range(0, 1)), ($urandom % 4) != 0, ($urandom % 16) == 0);
        repeat (4) step(0, 0, 0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
